// File: rtl/proc_pkg.sv
// Shared definitions for proc_core: opcodes, FSM states,
// instruction field positions and fault codes.
package proc_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_LDI  = 4'h6,
        OP_LD   = 4'h7,
        OP_ST   = 4'h8,
        OP_JMP  = 4'h9,
        OP_JZ   = 4'hA,
        OP_JC   = 4'hB,
        OP_CALL = 4'hC,
        OP_RET  = 4'hD,
        OP_HALT = 4'hE,
        OP_ILL  = 4'hF
    } op_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT,
        S_FAULT
    } st_e;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 9;
    localparam int RS_HI  = 8;
    localparam int RS_LO  = 6;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    localparam logic [1:0] F_ILLEGAL   = 2'd1;
    localparam logic [1:0] F_OVERFLOW  = 2'd2;
    localparam logic [1:0] F_UNDERFLOW = 2'd3;

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address stack; dout shows the top entry,
// full/empty guard the caller against overflow/underflow.
module ret_stack #(
    parameter int AW     = 8,
    parameter int SDEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [AW-1:0] din,
    output logic [AW-1:0] dout,
    output logic          full,
    output logic          empty
);
    localparam int PW = $clog2(SDEPTH);

    logic [AW-1:0] mem [SDEPTH];
    logic [PW:0]   sp;

    assign full  = (sp == (PW+1)'(SDEPTH));
    assign empty = (sp == '0);
    assign dout  = mem[sp[PW-1:0] - 1'b1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sp <= '0;
        end else if (push) begin
            sp <= sp + 1'b1;
        end else if (pop) begin
            sp <= sp - 1'b1;
        end
    end

    // Entries are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[sp[PW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/proc_core.sv
// proc_core: multicycle core (FETCH/EXEC/MEM/HALT/FAULT) with
// req/ack instruction and data ports and a return stack.
module proc_core
    import proc_pkg::*;
#(
    parameter int DW     = 16,
    parameter int AW     = 8,
    parameter int SDEPTH = 8
) (
    input  logic          clkin,
    input  logic          Rst,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic [15:0]   imem_rdata,
    input  logic          imem_ack,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ack,
    output logic          halted,
    output logic          fault,
    output logic [1:0]    fault_code
);
    st_e           state;
    logic [15:0]   ir;
    logic [AW-1:0] pc, pc_inc, target, sdout;
    logic          zf, cf;
    logic [DW-1:0] regs [8];
    op_e           op;
    logic [2:0]    rd_i, rs_i;
    logic [DW-1:0] rd_v, rs_v, imm_d;
    logic [DW:0]   alu;
    logic          is_alu, push, pop, sfull, sempty;

    assign op        = op_e'(ir[OP_HI:OP_LO]);
    assign rd_i      = ir[RD_HI:RD_LO];
    assign rs_i      = ir[RS_HI:RS_LO];
    assign imm_d     = DW'(ir[IMM_HI:IMM_LO]);
    assign target    = AW'(ir[IMM_HI:IMM_LO]);
    assign rd_v      = regs[rd_i];
    assign rs_v      = regs[rs_i];
    assign pc_inc    = pc + AW'(1);
    assign imem_addr = pc;

    assign push = (state == S_EXEC) && (op == OP_CALL) && !sfull;
    assign pop  = (state == S_EXEC) && (op == OP_RET) && !sempty;

    ret_stack #(.AW(AW), .SDEPTH(SDEPTH)) u_stack (
        .clk   (clkin),
        .rst_n (Rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (sdout),
        .full  (sfull),
        .empty (sempty)
    );

    // Bit DW carries ADD carry-out or SUB borrow.
    always_comb begin
        alu    = '0;
        is_alu = 1'b1;
        unique case (op)
            OP_ADD:  alu = {1'b0, rd_v} + {1'b0, rs_v};
            OP_SUB:  alu = {rs_v > rd_v, rd_v - rs_v};
            OP_AND:  alu = {1'b0, rd_v & rs_v};
            OP_OR:   alu = {1'b0, rd_v | rs_v};
            OP_XOR:  alu = {1'b0, rd_v ^ rs_v};
            default: is_alu = 1'b0;
        endcase
    end

    always_ff @(posedge clkin) begin
        if (Rst && state == S_EXEC && is_alu) begin
            regs[rd_i] <= alu[DW-1:0];
        end else if (Rst && state == S_EXEC && op == OP_LDI) begin
            regs[rd_i] <= imm_d;
        end else if (Rst && state == S_MEM && dmem_ack && !dmem_we) begin
            regs[rd_i] <= dmem_rdata;
        end
    end

    always_ff @(posedge clkin) begin
        if (!Rst) begin
            state      <= S_FETCH;
            ir         <= '0;
            pc         <= '0;
            zf         <= 1'b0;
            cf         <= 1'b0;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            halted     <= 1'b0;
            fault      <= 1'b0;
            fault_code <= '0;
        end else begin
            unique case (state)
                S_FETCH: begin
                    // An ack before our request is raised is ignored.
                    if (!imem_req) begin
                        imem_req <= 1'b1;
                    end else if (imem_ack) begin
                        ir       <= imem_rdata;
                        imem_req <= 1'b0;
                        state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                    pc       <= pc_inc;
                    if (is_alu) begin
                        zf <= (alu[DW-1:0] == '0);
                        cf <= alu[DW];
                    end
                    unique case (op)
                        OP_LD, OP_ST: begin
                            state      <= S_MEM;
                            imem_req   <= 1'b0;
                            dmem_req   <= 1'b1;
                            dmem_we    <= (op == OP_ST);
                            dmem_addr  <= AW'(rs_v);
                            dmem_wdata <= rd_v;
                        end
                        OP_JMP: pc <= target;
                        OP_JZ:  if (zf) pc <= target;
                        OP_JC:  if (cf) pc <= target;
                        OP_CALL: begin
                            if (sfull) begin
                                state      <= S_FAULT;
                                imem_req   <= 1'b0;
                                pc         <= pc;
                                fault      <= 1'b1;
                                fault_code <= F_OVERFLOW;
                            end else begin
                                pc <= target;
                            end
                        end
                        OP_RET: begin
                            if (sempty) begin
                                state      <= S_FAULT;
                                imem_req   <= 1'b0;
                                pc         <= pc;
                                fault      <= 1'b1;
                                fault_code <= F_UNDERFLOW;
                            end else begin
                                pc <= sdout;
                            end
                        end
                        OP_HALT: begin
                            state    <= S_HALT;
                            imem_req <= 1'b0;
                            pc       <= pc;
                            halted   <= 1'b1;
                        end
                        OP_ILL: begin
                            state      <= S_FAULT;
                            imem_req   <= 1'b0;
                            pc         <= pc;
                            fault      <= 1'b1;
                            fault_code <= F_ILLEGAL;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/proc_core.md
# proc_core

Parametrised multicycle processor core; the successor to the fixed-width processor top. It integrates fetch, decode, ALU, an 8-entry register file, a Z/C flag register and a hardware return-address stack behind one FSM. It talks to separate instruction and data memories over req/ack handshakes, so wait-stated memories work. It adds CALL/RET, HALT and fault reporting, which the previous generation lacked.

## Interface
- `DW`, default 16: data/register width, ≥ 8.
- `AW`, default 8: instruction and data address width, ≥ 8.
- `SDEPTH`, default 8: return-stack depth, power of two, ≥ 2.
- `clkin` in 1: sole clock, rising edge.
- `Rst` in 1: reset, synchronous, active-low.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out AW: fetch address, equal to PC.
- `imem_rdata` in 16: instruction word.
- `imem_ack` in 1: fetch complete; `imem_rdata` valid this cycle.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: 1 = store, 0 = load.
- `dmem_addr` out AW: low AW bits of `rs`.
- `dmem_wdata` out DW: value of `rd`.
- `dmem_rdata` in DW: load data.
- `dmem_ack` in 1: data access complete.
- `halted` out 1: core stopped by HALT.
- `fault` out 1: core stopped by an error.
- `fault_code` out 2: 1 = illegal opcode, 2 = stack overflow, 3 = stack underflow.

## Operation
- Instruction fields: `op`[15:12], `rd`[11:9], `rs`[8:6], `imm`[7:0].
  - Immediates are zero-extended to DW or AW as needed.
  - Every arithmetic and logic result is truncated to DW.
- Opcodes:
  - 0 NOP.
  - 1 ADD: rd += rs; C = carry out.
  - 2 SUB: rd −= rs; C = borrow, i.e. rs > rd unsigned.
  - 3 AND, 4 OR, 5 XOR: C ← 0.
  - 6 LDI: rd = imm; flags unchanged.
  - 7 LD: rd = dmem[rs].
  - 8 ST: dmem[rs] = rd.
  - 9 JMP imm.
  - A JZ imm, taken if Z = 1.
  - B JC imm, taken if C = 1.
  - C CALL imm: push PC+1, then jump.
  - D RET: pop into PC.
  - E HALT.
  - F illegal.
- Flags:
  - Z = (result == 0).
  - Z and C update only on opcodes 1–5.
- FSM states: FETCH, EXEC, MEM, HALT, FAULT.
  - FETCH: assert `imem_req`. On `imem_ack`, latch IR and go to EXEC.
  - EXEC, opcodes 0–6 and 9–B: commit the result, set the next PC (sequential PC+1 or branch target), go to FETCH.
  - EXEC, opcode 7 or 8: go to MEM.
  - EXEC, CALL with the stack full: go to FAULT, code 2. No push, PC unchanged.
  - EXEC, RET with the stack empty: go to FAULT, code 3.
  - EXEC, opcode E: go to HALT.
  - EXEC, opcode F: go to FAULT, code 1.
  - MEM: assert `dmem_req`. On `dmem_ack`, write rd for LD and go to FETCH.
  - HALT and FAULT are terminal; only reset leaves them.
- PC wraps modulo 2^AW; 0xFF+1 → 0x00 when AW = 8.
- On HALT or fault, PC stays at the address of the offending instruction.
- Registers hold their values. The registers and the stack are not reset; only PC, stack pointer, flags, FSM and outputs are.

## Timing
- While Rst = 0, at the next edge:
  - All outputs go to 0.
  - PC, SP, Z and C go to 0.
  - FSM goes to FETCH.
- First `imem_req` is high in the first cycle after Rst samples 1, with `imem_addr` = 0.
- Handshake, for both ports:
  - req, addr, we and wdata hold stable until ack is sampled high.
  - req drops the cycle after ack.
  - ack with req low is ignored.
  - ack in the same cycle as req is legal (zero wait states).
- Latency with zero-wait memory:
  - ALU, branch, CALL, RET: 2 cycles.
  - LD, ST: 3 cycles.
  - Each memory wait cycle adds 1.
- Register write, flag update and PC update all occur at the edge that leaves EXEC; for LD the write occurs at the edge that leaves MEM.
- `halted` and `fault` assert in the cycle after the EXEC edge and stay high until reset.
- Reset mid-transaction:
  - req drops at the reset edge.
  - An ack arriving in the first cycle after reset, before any new request, is ignored.
- Simultaneous push and pop cannot occur: CALL and RET are separate instructions.

## Structure
- Package `proc_pkg` holds:
  - the opcode enum;
  - the FSM state enum;
  - field bit positions;
  - fault-code constants.
- Sub-module `ret_stack` (parameters AW, SDEPTH):
  - inputs: push, pop, din;
  - outputs: dout, full, empty;
  - its SP resets to 0.
- ALU, register file and flags are inline in `proc_core`.

## Test plan
- LDI r1,0x05; LDI r2,0x05; SUB r1,r2; JZ 0x10 → PC = 0x10, Z = 1, C = 0, r1 = 0.
- ADD with r1 = 0xFFFF and r2 = 0x0001 (DW = 16) → r1 = 0, Z = 1, C = 1. A following AND → C = 0.
- ST r3 → [r4], then LD r5 ← [r4], with 2-cycle `dmem_ack` delay → r5 = r3. Each access takes 5 cycles total; req stays high until ack.
- Nested CALLs, SDEPTH = 8:
  - 8 CALLs then 8 RETs → PC returns to the instruction after the first CALL.
  - A 9th CALL → `fault` = 1, `fault_code` = 2.
- RET right after reset → `fault_code` = 3. Opcode 0xF → `fault_code` = 1. HALT → `halted` = 1 and no further `imem_req`.
- Reset with `imem_req` pending and a late `imem_ack` → ack ignored. The next fetch is at address 0 and the outputs read 0 during reset.
